beam_sel_enc: RTL and testbench
===============================

BEAM_SEL_ENC -- requirements
Module: beam_sel_enc

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4, number of consecutive identical samples needed to qualify a request (legal range 2..15).
REQ-002 SHALL have port clk, input, 1 bit, single rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-004 SHALL have port en, input, 1 bit, block enable; low forces the block idle.
REQ-005 SHALL have port f, input, 7 bits indexed [7:1], element-select lines with one line per beam position.
REQ-006 SHALL have port ready, input, 1 bit, consumer accepts the offered code.
REQ-007 SHALL have port sel, output, 5 bits, encoded beam-select code.
REQ-008 SHALL have port valid, output, 1 bit, sel/err offered to the consumer.
REQ-009 SHALL have port err, output, 1 bit, qualified request was not one-hot.

Function
REQ-010 Encoding SHALL be f[i] one-hot -> sel = 6 + 2*(i-1), giving 5'b00110, 01000, 01010, 01100, 01110, 10000, 10010 for i=1..7.
REQ-011 The block SHALL implement FSM states IDLE, QUAL, OFFER, RELEASE, with all outputs registered.
REQ-012 IDLE: with en=1 and f!=0 sampled at an edge, the block SHALL capture f into snap, set cnt=1 and go to QUAL; otherwise it SHALL stay in IDLE.
REQ-013 QUAL: with en=1 and f==snap, cnt SHALL increment; on the edge where cnt would reach STABLE_CYC the FSM SHALL go to OFFER and load sel/err.
REQ-014 QUAL: with en=1 and f!=snap and f!=0, the block SHALL recapture snap=f and set cnt=1 (the count restarts).
REQ-015 QUAL: with f==0 or en=0, the FSM SHALL go to IDLE and cnt SHALL clear.
REQ-016 Latency: valid SHALL rise after the STABLE_CYC-th consecutive edge sampling identical nonzero f with en=1, i.e. STABLE_CYC edges from first sample.
REQ-017 On entry to OFFER, a one-hot snap SHALL load sel=encode(snap) and err=0; a multi-hot snap SHALL load sel=5'b00000 and err=1.
REQ-018 OFFER: valid=1, and sel/err SHALL hold constant regardless of f until the handshake.
REQ-019 Handshake: valid=1 and ready=1 sampled at an edge SHALL complete the transfer; at that edge valid, sel and err SHALL clear and the FSM SHALL go to RELEASE.
REQ-020 ready=1 while valid=0 SHALL have no effect.
REQ-021 en=0 in OFFER SHALL drop valid, sel and err to 0 and send the FSM to IDLE (offer withdrawn) at the next edge; en=0 takes priority over a simultaneous ready=1.
REQ-022 RELEASE: the FSM SHALL wait until f==0 or en=0, then go to IDLE; a held request SHALL produce exactly one transfer.
REQ-023 cnt SHALL be 4 bits and saturate, never wrapping.

Reset
REQ-024 rst=1 at an edge SHALL force state IDLE, cnt=0, snap=0, sel=5'b00000, valid=0, err=0, overriding every other input, including mid-QUAL and mid-OFFER.
REQ-025 The first edge with rst=0 SHALL be treated as an IDLE cycle, so f already asserted then qualifies normally.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the seven legal sel code constants, and the encode function (index -> code).
REQ-027 The seven sel code constants SHALL be the same constants used by the existing select-line decoder.
REQ-028 A sub-module beam_sel_stab SHALL contain the snap/cnt stability qualifier and output a one-cycle "qualified" pulse plus snap; beam_sel_enc SHALL contain the FSM and encoding.

Verification
REQ-029 Directed test: en=1, f=7'b0000100 held, ready=1 -> valid high for one cycle, sel=5'b01010, err=0, valid rising 4 edges after first sample; no second transfer while f held.
REQ-030 Directed test: f=7'b0000001 for 2 cycles, then 7'b1000000 held -> no valid until 4 edges after the change, then sel=5'b10010.
REQ-031 Directed test: f=7'b0000011 held -> valid=1, err=1, sel=5'b00000.
REQ-032 Directed test: qualified f=7'b0001000, ready=0 for 10 cycles with f changing -> sel=5'b01100 held steady; ready=1 completes the transfer in one cycle.
REQ-033 Directed test: rst=1 in OFFER, or en=0 with ready=1 the same cycle -> next edge valid=0, sel=0, err=0, state IDLE.
REQ-034 Directed test: loop i=1..7, each pulse held 5 cycles then f=0 -> each sel matches REQ-010, with a decode round trip via the existing select-line decoder returning f.

Source files
------------

// File: rtl/beam_sel_enc_pkg.sv
// Shared types and beam-select code constants for the beam select encoder.
// decode() is the select-line decoder's mapping of the same codes back to lines.
package beam_sel_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_OFFER   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [4:0] SEL_NONE = 5'b00000;
    localparam logic [4:0] SEL_F1   = 5'b00110;
    localparam logic [4:0] SEL_F2   = 5'b01000;
    localparam logic [4:0] SEL_F3   = 5'b01010;
    localparam logic [4:0] SEL_F4   = 5'b01100;
    localparam logic [4:0] SEL_F5   = 5'b01110;
    localparam logic [4:0] SEL_F6   = 5'b10000;
    localparam logic [4:0] SEL_F7   = 5'b10010;

    function automatic logic [4:0] encode(input logic [2:0] idx);
        logic [4:0] code;
        case (idx)
            3'd1:    code = SEL_F1;
            3'd2:    code = SEL_F2;
            3'd3:    code = SEL_F3;
            3'd4:    code = SEL_F4;
            3'd5:    code = SEL_F5;
            3'd6:    code = SEL_F6;
            3'd7:    code = SEL_F7;
            default: code = SEL_NONE;
        endcase
        return code;
    endfunction

    function automatic logic [7:1] decode(input logic [4:0] code);
        logic [7:1] lines;
        case (code)
            SEL_F1:  lines = 7'b0000001;
            SEL_F2:  lines = 7'b0000010;
            SEL_F3:  lines = 7'b0000100;
            SEL_F4:  lines = 7'b0001000;
            SEL_F5:  lines = 7'b0010000;
            SEL_F6:  lines = 7'b0100000;
            SEL_F7:  lines = 7'b1000000;
            default: lines = 7'b0000000;
        endcase
        return lines;
    endfunction

endpackage

// File: rtl/beam_sel_enc_stab.sv
// Stability qualifier: counts consecutive identical nonzero samples of f and
// strobes qualified (combinationally) on the edge the count reaches STABLE_CYC.
module beam_sel_stab #(
    parameter int STABLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       track,
    input  logic [7:1] f,
    output logic       qualified,
    output logic [7:1] snap
);
    localparam logic [3:0] TARGET = 4'(STABLE_CYC);

    logic [3:0] cnt;
    logic       hit;
    logic       same;

    always_comb begin
        hit       = track && en && (f != 7'd0);
        same      = (cnt != 4'd0) && (f == snap);
        qualified = hit && same && ((cnt + 4'd1) == TARGET);
    end

    // A qualifying edge clears the count; the FSM has left QUAL by then.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 4'd0;
            snap <= 7'd0;
        end else if (!hit || qualified) begin
            cnt <= 4'd0;
        end else if (!same) begin
            snap <= f;
            cnt  <= 4'd1;
        end else if (cnt != 4'hF) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/beam_sel_enc.sv
// Beam select encoder: qualifies a stable element-select request, encodes it
// and offers it to the consumer with a valid/ready handshake.
module beam_sel_enc
    import beam_sel_enc_pkg::*;
#(
    parameter int STABLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:1] f,
    input  logic       ready,
    output logic [4:0] sel,
    output logic       valid,
    output logic       err
);
    state_t     state, next;
    logic       qualified;
    logic [7:1] snap;
    logic       onehot;
    logic [2:0] idx;
    logic [4:0] sel_d;
    logic       valid_d;
    logic       err_d;

    beam_sel_stab #(.STABLE_CYC(STABLE_CYC)) u_stab (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .track     ((state == ST_IDLE) || (state == ST_QUAL)),
        .f         (f),
        .qualified (qualified),
        .snap      (snap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sel   <= SEL_NONE;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= next;
            sel   <= sel_d;
            valid <= valid_d;
            err   <= err_d;
        end
    end

    always_comb begin
        next = state;
        case (state)
            ST_IDLE:    if (en && (f != 7'd0)) next = ST_QUAL;
            ST_QUAL:    if (!en || (f == 7'd0)) next = ST_IDLE;
                        else if (qualified) next = ST_OFFER;
            ST_OFFER:   if (!en) next = ST_IDLE;
                        else if (ready) next = ST_RELEASE;
            ST_RELEASE: if (!en || (f == 7'd0)) next = ST_IDLE;
            default:    next = ST_IDLE;
        endcase
    end

    always_comb begin
        idx = 3'd0;
        for (int i = 1; i <= 7; i++) begin
            if (snap[i]) idx = 3'(i);
        end
        onehot = (snap != 7'd0) && ((snap & (snap - 7'd1)) == 7'd0);
    end

    always_comb begin
        sel_d   = SEL_NONE;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state)
            ST_QUAL: begin
                if (next == ST_OFFER) begin
                    valid_d = 1'b1;
                    sel_d   = onehot ? encode(idx) : SEL_NONE;
                    err_d   = !onehot;
                end
            end
            ST_OFFER: begin
                if (next == ST_OFFER) begin
                    valid_d = valid;
                    sel_d   = sel;
                    err_d   = err;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_beam_sel_enc.sv
// Directed bench for beam_sel_enc with hand-computed expectations.
module tb_beam_sel_enc;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:1] f;
    logic       ready;
    logic [4:0] sel;
    logic       valid;
    logic       err;

    int checks = 0;
    int errors = 0;

    beam_sel_enc #(.STABLE_CYC(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .f     (f),
        .ready (ready),
        .sel   (sel),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string name, input logic v, input logic [4:0] s, input logic e);
        checks++;
        if (valid !== v || sel !== s || err !== e) begin
            errors++;
            $display("FAIL %s: got valid=%b sel=%b err=%b, want valid=%b sel=%b err=%b",
                     name, valid, sel, err, v, s, e);
        end
    endtask

    task automatic flush();
        ready = 1'b1;
        f     = 7'd0;
        tick(3);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; f = 7'd0; ready = 1'b0;
        tick(2);
        expect_out("reset", 1'b0, 5'b00000, 1'b0);
    endtask

    task automatic test_basic();
        int lat;
        rst = 1'b0; en = 1'b1; f = 7'b0000100; ready = 1'b1;
        lat = 0;
        while (valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges, want 4", lat);
        end
        expect_out("basic_offer", 1'b1, 5'b01010, 1'b0);
        tick();
        expect_out("basic_accept", 1'b0, 5'b00000, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            expect_out("basic_no_repeat", 1'b0, 5'b00000, 1'b0);
        end
        flush();
    endtask

    task automatic test_restart();
        ready = 1'b0;
        f = 7'b0000001;
        tick(2);
        f = 7'b1000000;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out("restart_wait", 1'b0, 5'b00000, 1'b0);
        end
        tick();
        expect_out("restart_offer", 1'b1, 5'b10010, 1'b0);
        ready = 1'b1;
        tick();
        expect_out("restart_accept", 1'b0, 5'b00000, 1'b0);
        flush();
    endtask

    task automatic test_multihot();
        ready = 1'b0;
        f = 7'b0000011;
        tick(3);
        expect_out("multihot_wait", 1'b0, 5'b00000, 1'b0);
        tick();
        expect_out("multihot_offer", 1'b1, 5'b00000, 1'b1);
        ready = 1'b1;
        tick();
        expect_out("multihot_accept", 1'b0, 5'b00000, 1'b0);
        flush();
    endtask

    task automatic test_hold();
        logic [7:1] pat [10];
        pat = '{7'b0000001, 7'b0000000, 7'b1111111, 7'b0100000, 7'b0000000,
                7'b0000011, 7'b1000000, 7'b0001000, 7'b0000000, 7'b0010100};
        ready = 1'b0;
        f = 7'b0001000;
        tick(4);
        expect_out("hold_offer", 1'b1, 5'b01100, 1'b0);
        for (int k = 0; k < 10; k++) begin
            f = pat[k];
            tick();
            expect_out("hold_steady", 1'b1, 5'b01100, 1'b0);
        end
        ready = 1'b1;
        tick();
        expect_out("hold_accept", 1'b0, 5'b00000, 1'b0);
        flush();
    endtask

    task automatic test_abort();
        ready = 1'b0;
        f = 7'b0010000;
        tick(4);
        expect_out("abort_offer", 1'b1, 5'b01110, 1'b0);
        rst = 1'b1;
        tick();
        expect_out("abort_rst", 1'b0, 5'b00000, 1'b0);
        rst = 1'b0;
        tick(3);
        expect_out("abort_rst_requal_wait", 1'b0, 5'b00000, 1'b0);
        tick();
        expect_out("abort_rst_requal", 1'b1, 5'b01110, 1'b0);
        en = 1'b0; ready = 1'b1;
        tick();
        expect_out("abort_en_low", 1'b0, 5'b00000, 1'b0);
        // Back in IDLE (not RELEASE): the held request qualifies again.
        en = 1'b1; ready = 1'b0;
        tick(4);
        expect_out("abort_idle_requal", 1'b1, 5'b01110, 1'b0);
        flush();
    endtask

    task automatic test_sweep();
        logic [7:1] pulse;
        logic [4:0] want;
        logic [7:1] back;
        for (int i = 1; i <= 7; i++) begin
            pulse = 7'd1 << (i - 1);
            want  = 5'(6 + 2 * (i - 1));
            f = pulse; ready = 1'b1;
            tick(4);
            expect_out("sweep_sel", 1'b1, want, 1'b0);
            back = beam_sel_enc_pkg::decode(sel);
            checks++;
            if (back !== pulse) begin
                errors++;
                $display("FAIL sweep_roundtrip: i=%0d got f=%b want f=%b", i, back, pulse);
            end
            tick();
            expect_out("sweep_accept", 1'b0, 5'b00000, 1'b0);
            f = 7'd0;
            tick(2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart();
        test_multihot();
        test_hold();
        test_abort();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
